// File: rtl/qed_pkg.sv
// rtl/qed_pkg.sv - QED duplicator shared types, mode constants and register remap
// Purpose : mode values seen by the r[j] vs r[j+16] checker, FSM state enum,
//           SPARC register field positions and the original->duplicate remap.
// Ports   : none (package).
package qed_pkg;

  localparam int INSTR_W = 32;

  // Mode values; CHECK_MODE must match the value the consistency checker tests.
  localparam logic [1:0] ORIG_MODE  = 2'd0;
  localparam logic [1:0] DUP_MODE   = 2'd1;
  localparam logic [1:0] CHECK_MODE = 2'd2;

  typedef enum logic [1:0] {
    S_ORIG  = 2'd0,
    S_DUP   = 2'd1,
    S_DRAIN = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  // SPARC format field positions
  localparam int OP_LSB  = 30;
  localparam int RD_LSB  = 25;
  localparam int OP2_LSB = 22;
  localparam int RS1_LSB = 14;
  localparam int I_BIT   = 13;
  localparam int RS2_LSB = 0;

  localparam logic [2:0] OP2_SETHI = 3'b100;

  // r1..r15 -> r17..r31; r0 and already-high registers are left alone.
  function automatic logic [4:0] remap_field(input logic [4:0] f);
    remap_field = ((f != 5'd0) && !f[4]) ? {1'b1, f[3:0]} : f;
  endfunction

  function automatic logic [INSTR_W-1:0] remap(input logic [INSTR_W-1:0] x);
    logic [INSTR_W-1:0] y;
    y = x;
    if (x[OP_LSB+1]) begin
      // Format 3 (op=10/11): rd, rs1, and rs2 unless the immediate form is used.
      y[RD_LSB+:5]  = remap_field(x[RD_LSB+:5]);
      y[RS1_LSB+:5] = remap_field(x[RS1_LSB+:5]);
      if (!x[I_BIT]) begin
        y[RS2_LSB+:5] = remap_field(x[RS2_LSB+:5]);
      end
    end else if (!x[OP_LSB] && (x[OP2_LSB+:3] == OP2_SETHI)) begin
      y[RD_LSB+:5] = remap_field(x[RD_LSB+:5]);
    end
    return y;
  endfunction

endpackage

// File: rtl/qed_dup_injector_if.sv
// rtl/qed_dup_injector_if.sv - fetch-side and decode-side handshake bundle
// Purpose : groups the instruction input (from fetch) and output (to decode).
// Modports: slave  - the injector (consumes in_*, produces out_*)
//           master - the surrounding front end (produces in_*, consumes out_*)
interface qed_dup_injector_if #(
  parameter int IW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic          out_is_dup;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_is_dup
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_is_dup
  );
endinterface

// File: rtl/qed_dup_fifo.sv
// rtl/qed_dup_fifo.sv - originals buffer awaiting duplication
// Purpose : DEPTH x IW FIFO with synchronous clear and occupancy count.
// Ports   : clk, rst (async active-low); i_clear drops all entries;
//           i_push/i_data write; i_pop advances head; o_head is the oldest
//           entry; o_full/o_empty/o_count report occupancy (count==DEPTH is full).
module qed_dup_fifo #(
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [IW-1:0] i_data,
  input  logic          i_pop,
  output logic [IW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [IW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full & ~i_clear;
  assign w_do_pop  = i_pop & ~o_empty & ~i_clear;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/qed_dup_injector.sv
// rtl/qed_dup_injector.sv - QED instruction duplicator for the decode front end
// Purpose : passes originals through while buffering them, replays them with
//           r1..r15 remapped to r17..r31, then signals CHECK_MODE once every
//           duplicate has committed.
// Ports   : clk, rst (async active-low); ena (0 = transparent bypass);
//           exec_dup (start replay); pipe_empty (nothing between issue and
//           commit); bus (slave side of fetch/decode handshakes);
//           qed_mode (ORIG/DUP/CHECK); pending (originals awaiting duplication).
module qed_dup_injector
  import qed_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int CW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 exec_dup,
  input  logic                 pipe_empty,
  qed_dup_injector_if.slave    bus,
  output logic [1:0]           qed_mode,
  output logic [CW-1:0]        pending
);

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [IW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  logic          w_go_dup;

  qed_dup_fifo #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (~ena),
    .i_push  (w_push),
    .i_data  (bus.in_instr),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Handshake steering. Outputs toward decode are held quiet while in reset;
  // in_ready keeps following its combinational rule.
  always_comb begin
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_instr  = '0;
    bus.out_is_dup = 1'b0;
    if (!ena) begin
      bus.in_ready = bus.out_ready;
      if (rst) begin
        bus.out_valid = bus.in_valid;
        bus.out_instr = bus.in_instr;
      end
    end else begin
      case (r_state)
        S_ORIG: begin
          bus.in_ready = bus.out_ready & ~w_full;
          if (rst) begin
            bus.out_valid = bus.in_valid;
            bus.out_instr = bus.in_instr;
          end
        end
        S_DUP: begin
          if (rst) begin
            bus.out_valid  = ~w_empty;
            bus.out_instr  = remap(w_head);
            bus.out_is_dup = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_push = ena & (r_state == S_ORIG) & bus.in_valid & bus.in_ready;
  assign w_pop  = ena & (r_state == S_DUP) & bus.out_valid & bus.out_ready;

  // Replay decision looks at the occupancy after this cycle's push, so a push
  // coinciding with exec_dup (or filling the last slot) is kept and replayed.
  assign w_go_dup = (exec_dup & ((w_count != '0) | w_push)) |
                    w_full |
                    (w_push & (w_count == CW'(DEPTH - 1)));

  // qed_mode is registered alongside the state so it always matches it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_ORIG;
      r_mode  <= ORIG_MODE;
    end else if (!ena) begin
      r_state <= S_ORIG;
      r_mode  <= ORIG_MODE;
    end else begin
      case (r_state)
        S_ORIG: begin
          if (w_go_dup) begin
            r_state <= S_DUP;
            r_mode  <= DUP_MODE;
          end
        end
        S_DUP: begin
          if (w_pop && (w_count == CW'(1))) begin
            r_state <= S_DRAIN;
            r_mode  <= DUP_MODE;
          end
        end
        S_DRAIN: begin
          if (pipe_empty) begin
            r_state <= S_CHECK;
            r_mode  <= CHECK_MODE;
          end
        end
        default: begin
          r_state <= S_ORIG;
          r_mode  <= ORIG_MODE;
        end
      endcase
    end
  end

  assign qed_mode = r_mode;
  assign pending  = w_count;

endmodule

// File: tb/tb_qed_dup_injector.sv
// tb/tb_qed_dup_injector.sv - self-checking bench for qed_dup_injector
module tb_qed_dup_injector;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       exec_dup;
  logic       pipe_empty;
  logic [1:0] qed_mode;
  logic [3:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qed_dup_injector_if #(.IW(32)) bus ();

  qed_dup_injector #(
    .DEPTH (8),
    .IW    (32),
    .CW    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .exec_dup   (exec_dup),
    .pipe_empty (pipe_empty),
    .bus        (bus.slave),
    .qed_mode   (qed_mode),
    .pending    (pending)
  );

  // Reference remap: add 16 to any register field holding 1..15.
  function automatic logic [31:0] bump(input logic [31:0] v, input int pos);
    int unsigned f;
    f = (v >> pos) & 32'd31;
    if (f >= 1 && f <= 15) return v + (32'd16 << pos);
    return v;
  endfunction

  function automatic logic [31:0] ref_remap(input logic [31:0] x);
    logic [31:0] y;
    int unsigned op;
    op = x >> 30;
    y  = x;
    if (op >= 2) begin
      y = bump(y, 25);
      y = bump(y, 14);
      if (((x >> 13) & 32'd1) == 0) y = bump(y, 0);
    end else if (op == 0 && ((x >> 22) & 32'd7) == 4) begin
      y = bump(y, 25);
    end
    return y;
  endfunction

  // Eligible instruction: register fields in r0..r15; SETHI forced sometimes.
  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    x[29] = 1'b0;
    x[18] = 1'b0;
    x[4]  = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      x[31:30] = 2'b00;
      x[24:22] = 3'b100;
    end
    return x;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b1;
    exec_dup      = 1'b0;
    pipe_empty    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ena = 1'b1; idle_inputs();
    bus.in_valid = 1'b1; bus.in_instr = 32'h1234_5678;
    #2;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
    n_cmp++; if (bus.out_is_dup !== 1'b0) begin n_bad++; $display("FAIL reset_out_is_dup: got %b want 0", bus.out_is_dup); end
    n_cmp++; if (qed_mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode: got %0d want 0", qed_mode); end
    n_cmp++; if (pending !== 4'd0) begin n_bad++; $display("FAIL reset_pending: got %0d want 0", pending); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single(input string nm, input logic [31:0] ins, input logic [31:0] exp_dup);
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_instr = ins; exec_dup = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== ins || bus.out_is_dup !== 1'b0)
      begin n_bad++; $display("FAIL %s_orig: got v=%b %h d=%b want v=1 %h d=0", nm, bus.out_valid, bus.out_instr, bus.out_is_dup, ins); end
    n_cmp++; if (qed_mode !== 2'd0) begin n_bad++; $display("FAIL %s_mode_orig: got %0d want 0", nm, qed_mode); end
    cyc();
    bus.in_valid = 1'b0; exec_dup = 1'b0;
    #1;
    n_cmp++; if (qed_mode !== 2'd1) begin n_bad++; $display("FAIL %s_mode_dup: got %0d want 1", nm, qed_mode); end
    n_cmp++; if (pending !== 4'd1) begin n_bad++; $display("FAIL %s_pending: got %0d want 1", nm, pending); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_dup || bus.out_is_dup !== 1'b1)
      begin n_bad++; $display("FAIL %s_dup: got v=%b %h d=%b want v=1 %h d=1", nm, bus.out_valid, bus.out_instr, bus.out_is_dup, exp_dup); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_in_ready_dup: got %b want 0", nm, bus.in_ready); end
    cyc();
    n_cmp++; if (bus.out_valid !== 1'b0 || qed_mode !== 2'd1 || pending !== 4'd0)
      begin n_bad++; $display("FAIL %s_drain: got v=%b mode=%0d pend=%0d want 0/1/0", nm, bus.out_valid, qed_mode, pending); end
    cyc();
    n_cmp++; if (qed_mode !== 2'd1) begin n_bad++; $display("FAIL %s_drain_hold: got %0d want 1", nm, qed_mode); end
    pipe_empty = 1'b1;
    cyc();
    n_cmp++; if (qed_mode !== 2'd2) begin n_bad++; $display("FAIL %s_check: got %0d want 2", nm, qed_mode); end
    cyc();
    n_cmp++; if (qed_mode !== 2'd0) begin n_bad++; $display("FAIL %s_back_orig: got %0d want 0", nm, qed_mode); end
    pipe_empty = 1'b0;
  endtask

  task automatic test_fill_full();
    logic [31:0] q[$];
    logic [31:0] x;
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      x = rand_instr();
      q.push_back(x);
      bus.in_valid = 1'b1; bus.in_instr = x;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1 || pending !== 4'(i))
        begin n_bad++; $display("FAIL fill_push%0d: got rdy=%b pend=%0d want 1/%0d", i, bus.in_ready, pending, i); end
      cyc();
    end
    bus.in_valid = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0 || pending !== 4'd8 || qed_mode !== 2'd1)
      begin n_bad++; $display("FAIL fill_full: got rdy=%b pend=%0d mode=%0d want 0/8/1", bus.in_ready, pending, qed_mode); end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== ref_remap(q[i]) || pending !== 4'(8 - i))
        begin n_bad++; $display("FAIL fill_dup%0d: got v=%b %h pend=%0d want 1 %h %0d", i, bus.out_valid, bus.out_instr, pending, ref_remap(q[i]), 8 - i); end
      cyc();
    end
    n_cmp++; if (pending !== 4'd0 || qed_mode !== 2'd1 || bus.out_valid !== 1'b0)
      begin n_bad++; $display("FAIL fill_drain: got pend=%0d mode=%0d v=%b want 0/1/0", pending, qed_mode, bus.out_valid); end
    pipe_empty = 1'b1;
    cyc();
    cyc();
    n_cmp++; if (qed_mode !== 2'd0) begin n_bad++; $display("FAIL fill_end_mode: got %0d want 0", qed_mode); end
    pipe_empty = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] q[$];
    logic [31:0] x;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      x = rand_instr();
      q.push_back(x);
      bus.in_valid = 1'b1; bus.in_instr = x; exec_dup = (i == 3);
      cyc();
    end
    bus.in_valid = 1'b0; exec_dup = 1'b0;
    #1;
    n_cmp++; if (bus.out_instr !== ref_remap(q[0])) begin n_bad++; $display("FAIL stall_first: got %h want %h", bus.out_instr, ref_remap(q[0])); end
    cyc();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== ref_remap(q[1]) || pending !== 4'd3)
        begin n_bad++; $display("FAIL stall_hold%0d: got v=%b %h pend=%0d want 1 %h 3", i, bus.out_valid, bus.out_instr, pending, ref_remap(q[1])); end
      cyc();
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.out_instr !== ref_remap(q[i]) || pending !== 4'(4 - i))
        begin n_bad++; $display("FAIL stall_resume%0d: got %h pend=%0d want %h %0d", i, bus.out_instr, pending, ref_remap(q[i]), 4 - i); end
      cyc();
    end
    pipe_empty = 1'b1;
    cyc();
    cyc();
    n_cmp++; if (qed_mode !== 2'd0) begin n_bad++; $display("FAIL stall_end_mode: got %0d want 0", qed_mode); end
    pipe_empty = 1'b0;
  endtask

  task automatic test_ena_drop();
    logic [31:0] y;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_instr = rand_instr(); exec_dup = (i == 2);
      cyc();
    end
    bus.in_valid = 1'b0; exec_dup = 1'b0; bus.out_ready = 1'b0;
    #1;
    n_cmp++; if (pending !== 4'd3 || qed_mode !== 2'd1)
      begin n_bad++; $display("FAIL ena_pre: got pend=%0d mode=%0d want 3/1", pending, qed_mode); end
    ena = 1'b0;
    cyc();
    n_cmp++; if (pending !== 4'd0 || qed_mode !== 2'd0)
      begin n_bad++; $display("FAIL ena_abort: got pend=%0d mode=%0d want 0/0", pending, qed_mode); end
    y = $urandom;
    bus.in_valid = 1'b1; bus.in_instr = y; bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== y || bus.in_ready !== 1'b1 || bus.out_is_dup !== 1'b0)
      begin n_bad++; $display("FAIL ena_bypass: got v=%b %h rdy=%b d=%b want 1 %h 1 0", bus.out_valid, bus.out_instr, bus.in_ready, bus.out_is_dup, y); end
    bus.out_ready = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL ena_bypass_ready: got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cyc();
    ena = 1'b1;
    cyc();
    n_cmp++; if (pending !== 4'd0 || qed_mode !== 2'd0)
      begin n_bad++; $display("FAIL ena_restore: got pend=%0d mode=%0d want 0/0", pending, qed_mode); end
  endtask

  task automatic test_reset_in_drain();
    idle_inputs();
    bus.in_valid = 1'b1; bus.in_instr = rand_instr(); exec_dup = 1'b1;
    cyc();
    bus.in_valid = 1'b0; exec_dup = 1'b0;
    cyc();
    n_cmp++; if (qed_mode !== 2'd1 || bus.out_valid !== 1'b0)
      begin n_bad++; $display("FAIL rstdrain_pre: got mode=%0d v=%b want 1/0", qed_mode, bus.out_valid); end
    bus.in_valid = 1'b1; bus.in_instr = 32'hDEAD_BEEF;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || qed_mode !== 2'd0 || pending !== 4'd0)
      begin n_bad++; $display("FAIL rstdrain_async: got v=%b mode=%0d pend=%0d want 0/0/0", bus.out_valid, qed_mode, pending); end
    bus.in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  // Cycle-level reference: a queue of buffered originals plus a phase
  // (0 pass-through, 1 replay, 2 wait for commit, 3 check cycle).
  task automatic test_random();
    logic [31:0] q[$];
    int          phase;
    logic [31:0] ins;
    logic        exp_v, exp_rdy, exp_dup;
    logic [31:0] exp_ins;
    logic [1:0]  exp_mode;
    phase = 0;
    idle_inputs();
    for (int c = 0; c < 420; c++) begin
      ins = rand_instr();
      if (c < 400) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        exec_dup      = ($urandom_range(0, 7) == 0);
        pipe_empty    = ($urandom_range(0, 1) == 0);
      end else begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; exec_dup = 1'b1; pipe_empty = 1'b1;
      end
      bus.in_instr = ins;
      #1;
      exp_mode = (phase == 0) ? 2'd0 : (phase == 3) ? 2'd2 : 2'd1;
      exp_v    = (phase == 0) ? bus.in_valid : (phase == 1) ? (q.size() > 0) : 1'b0;
      exp_rdy  = (phase == 0) ? (bus.out_ready && q.size() < 8) : 1'b0;
      exp_dup  = (phase == 1);
      exp_ins  = (phase == 1 && q.size() > 0) ? ref_remap(q[0]) : ins;
      n_cmp++; if (qed_mode !== exp_mode) begin n_bad++; $display("FAIL rand_mode c%0d: got %0d want %0d", c, qed_mode, exp_mode); end
      n_cmp++; if (pending !== 4'(q.size())) begin n_bad++; $display("FAIL rand_pending c%0d: got %0d want %0d", c, pending, q.size()); end
      n_cmp++; if (bus.out_valid !== exp_v) begin n_bad++; $display("FAIL rand_valid c%0d: got %b want %b", c, bus.out_valid, exp_v); end
      n_cmp++; if (bus.in_ready !== exp_rdy) begin n_bad++; $display("FAIL rand_ready c%0d: got %b want %b", c, bus.in_ready, exp_rdy); end
      if (exp_v) begin
        n_cmp++; if (bus.out_instr !== exp_ins || bus.out_is_dup !== exp_dup)
          begin n_bad++; $display("FAIL rand_instr c%0d: got %h d=%b want %h d=%b", c, bus.out_instr, bus.out_is_dup, exp_ins, exp_dup); end
      end
      case (phase)
        0: begin
          if (bus.in_valid && bus.out_ready && q.size() < 8) q.push_back(ins);
          if ((exec_dup && q.size() > 0) || q.size() == 8) phase = 1;
        end
        1: begin
          if (q.size() > 0 && bus.out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) phase = 2;
          end
        end
        2: if (pipe_empty) phase = 3;
        default: phase = 0;
      endcase
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single("add_reg", 32'h8600_4002, 32'hA604_4012);
    test_single("add_imm", 32'h8600_6005, 32'hA604_6005);
    test_single("or_r0",   32'h8210_0000, 32'hA210_0000);
    test_fill_full();
    test_stall();
    test_ena_drop();
    test_reset_in_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
